// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  // Frame length field size in bytes (LEN_LO, LEN_HI).
  localparam int unsigned LEN_BYTES      = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/imem_loader_word_asm.sv
// Little-endian word assembler for the program loader.
// Collects BYTES_PER_WORD accepted bytes, LSB first, and pulses word_valid_o for one cycle
// after the last byte of a word, with the assembled word on word_o.
// Ports:
//   clk_i, rst_ni  clock and synchronous active-low reset
//   clear_i        restart assembly at lane 0 (new load)
//   byte_valid_i   a payload byte is accepted this cycle
//   byte_i         payload byte
//   last_byte_o    the byte accepted this cycle completes a word
//   word_o         assembled word (stable while word_valid_o is high)
//   word_valid_o   one-cycle pulse, the cycle after the completing byte
module imem_loader_word_asm
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int unsigned LaneW = $clog2(BYTES_PER_WORD);

  logic [LaneW-1:0] lane_q, lane_d;
  logic [31:0]      word_q, word_d;
  logic             valid_q, valid_d;

  assign last_byte_o = byte_valid_i && (lane_q == LaneW'(BYTES_PER_WORD - 1));

  always_comb begin
    lane_d  = lane_q;
    word_d  = word_q;
    valid_d = 1'b0;
    if (clear_i) begin
      lane_d = '0;
      word_d = '0;
    end else if (byte_valid_i) begin
      // Shift in from the top: after four bytes, byte 0 sits in bits [7:0].
      word_d  = {byte_i, word_q[31:8]};
      lane_d  = lane_q + LaneW'(1);
      valid_d = last_byte_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lane_q  <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      lane_q  <= lane_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Program loader: writer side of the instruction memory.
// Accepts a framed byte stream (LEN_LO, LEN_HI, 4*N payload bytes, XOR checksum), writes
// each little-endian word to instruction memory and holds the CPU in reset until a load
// completes with a good checksum. NUM_WORDS must not exceed 2**ADDR_W.
// Ports:
//   clk, reset            clock and synchronous active-low reset
//   start                 begin a new load (ignored while busy)
//   in_valid/in_ready/in_data  byte stream handshake
//   imem_we/imem_addr/imem_wdata  one-cycle word write to instruction memory
//   cpu_reset             active-high processor reset, low only after a good load
//   busy/done/error       load status
//   words_loaded          words written in the current or last load
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned CntW   = ADDR_W + 1;
  localparam logic [15:0] MaxLen = 16'(NUM_WORDS);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [CntW-1:0]   len_q, len_d;
  logic [CntW-1:0]   words_rx_q, words_rx_d;
  logic [CntW-1:0]   loaded_q, loaded_d;
  logic [7:0]        xor_q, xor_d;

  logic        accept, start_ok, data_byte, last_byte, word_valid;
  logic [15:0] len16;
  logic [31:0] word;

  assign in_ready  = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK};
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && (state_q inside {S_IDLE, S_DONE, S_ERROR});
  assign data_byte = accept && (state_q == S_DATA);
  assign len16     = {in_data, len_lo_q};

  imem_loader_word_asm u_word_asm (
    .clk_i        (clk),
    .rst_ni       (reset),
    .clear_i      (start_ok),
    .byte_valid_i (data_byte),
    .byte_i       (in_data),
    .last_byte_o  (last_byte),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    words_rx_d = words_rx_q;
    loaded_d   = loaded_q;
    xor_d      = xor_q;

    if (word_valid) loaded_d = loaded_q + CntW'(1);

    if (start_ok) begin
      state_d    = S_LEN_LO;
      words_rx_d = '0;
      loaded_d   = '0;
      xor_d      = '0;
    end else begin
      unique case (state_q)
        S_LEN_LO: begin
          if (accept) begin
            len_lo_d = in_data;
            state_d  = S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            if (len16 == 16'd0) begin
              state_d = S_CHECK;
            end else if (len16 > MaxLen) begin
              state_d = S_ERROR;
            end else begin
              len_d   = len16[CntW-1:0];
              state_d = S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            xor_d = xor_q ^ in_data;
            if (last_byte) begin
              words_rx_d = words_rx_q + CntW'(1);
              if (words_rx_q == len_q - CntW'(1)) state_d = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          if (accept) state_d = (in_data == xor_q) ? S_DONE : S_ERROR;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      len_lo_q   <= '0;
      len_q      <= '0;
      words_rx_q <= '0;
      loaded_q   <= '0;
      xor_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_lo_q   <= len_lo_d;
      len_q      <= len_d;
      words_rx_q <= words_rx_d;
      loaded_q   <= loaded_d;
      xor_q      <= xor_d;
    end
  end

  // Gated by reset so a write pending in the reset cycle never reaches memory.
  assign imem_we      = word_valid && reset;
  assign imem_addr    = loaded_q[ADDR_W-1:0];
  assign imem_wdata   = word;
  assign words_loaded = loaded_q;
  assign busy         = in_ready;
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign cpu_reset    = (state_q != S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, imem_we, cpu_reset, busy, done, error;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  words_loaded;

  int checks = 0;
  int failures = 0;

  logic [7:0]  frm[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.ADDR_W(8), .NUM_WORDS(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Write monitor: records every memory write seen mid-cycle.
  always @(negedge clk) begin
    if (imem_we) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: byte %h not accepted, in_ready=%b want 1", b, in_ready);
        break;
      end
    end
    tick();
  endtask

  task automatic send_frame(input int max_gap);
    int g;
    for (int i = 0; i < frm.size(); i++) begin
      g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      in_valid = 1'b0;
      repeat (g) tick();
      send(frm[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic basic_frame(input logic [7:0] chk);
    frm = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, chk};
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({cpu_reset, in_ready, imem_we, busy, done, error} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_flags: got %b want 100000",
               {cpu_reset, in_ready, imem_we, busy, done, error});
    end
    checks++;
    if ({imem_addr, imem_wdata, words_loaded} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h wl=%0d want all 0",
               imem_addr, imem_wdata, words_loaded);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic_load(input int max_gap, input string nm);
    clear_log();
    pulse_start();
    @(negedge clk);
    checks++;
    if ({busy, in_ready, cpu_reset, words_loaded} !== {3'b111, 9'd0}) begin
      failures++;
      $display("FAIL %s_start: busy/ready/cpu_reset/wl got %b %b %b %0d want 1 1 1 0",
               nm, busy, in_ready, cpu_reset, words_loaded);
    end
    tick();
    basic_frame(8'h66);
    send_frame(max_gap);
    tick();
    @(negedge clk);
    checks++;
    if (wr_addr.size() != 2) begin
      failures++;
      $display("FAIL %s_wr_count: got %0d want 2", nm, wr_addr.size());
    end
    checks++;
    if ({wr_addr[0], wr_data[0]} !== {8'd0, 32'h11223344}) begin
      failures++;
      $display("FAIL %s_wr0: got %h/%h want 00/11223344", nm, wr_addr[0], wr_data[0]);
    end
    checks++;
    if ({wr_addr[1], wr_data[1]} !== {8'd1, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL %s_wr1: got %h/%h want 01/deadbeef", nm, wr_addr[1], wr_data[1]);
    end
    checks++;
    if ({done, error, cpu_reset, busy, words_loaded} !== {4'b1000, 9'd2}) begin
      failures++;
      $display("FAIL %s_status: done/err/cpu_rst/busy/wl got %b%b%b%b %0d want 1000 2",
               nm, done, error, cpu_reset, busy, words_loaded);
    end
  endtask

  task automatic test_bad_checksum();
    clear_log();
    pulse_start();
    basic_frame(8'h67);
    send_frame(0);
    tick();
    @(negedge clk);
    checks++;
    if (wr_addr.size() != 2 || wr_data[0] !== 32'h11223344 || wr_data[1] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL badchk_writes: count=%0d d0=%h d1=%h want 2 11223344 deadbeef",
               wr_addr.size(), wr_data[0], wr_data[1]);
    end
    checks++;
    if ({done, error, cpu_reset, busy} !== 4'b0110) begin
      failures++;
      $display("FAIL badchk_status: done/err/cpu_rst/busy got %b%b%b%b want 0110",
               done, error, cpu_reset, busy);
    end
  endtask

  task automatic test_zero_and_oversize();
    clear_log();
    pulse_start();
    frm = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    @(negedge clk);
    checks++;
    if ({done, error, cpu_reset, words_loaded} !== {3'b100, 9'd0} || wr_addr.size() != 0) begin
      failures++;
      $display("FAIL zero_len: done/err/cpu_rst %b%b%b wl=%0d writes=%0d want 100 0 0",
               done, error, cpu_reset, words_loaded, wr_addr.size());
    end
    tick();
    pulse_start();
    frm = '{8'h41, 8'h00};
    send_frame(0);
    @(negedge clk);
    checks++;
    if ({error, done, in_ready, busy, cpu_reset} !== 5'b10001) begin
      failures++;
      $display("FAIL oversize_status: err/done/ready/busy/cpu_rst got %b%b%b%b%b want 10001",
               error, done, in_ready, busy, cpu_reset);
    end
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (wr_addr.size() != 0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL oversize_nowrite: writes=%0d in_ready=%b want 0 0",
               wr_addr.size(), in_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    pulse_start();
    frm = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
    send_frame(0);
    // This cycle would carry the word-0 write.
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_we: imem_we got %b want 0", imem_we);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({cpu_reset, in_ready, imem_we, busy, done, error} !== 6'b100000 ||
        {imem_addr, imem_wdata, words_loaded} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: flags=%b addr=%h wdata=%h wl=%0d want 100000 0 0 0",
               {cpu_reset, in_ready, imem_we, busy, done, error}, imem_addr, imem_wdata,
               words_loaded);
    end
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if (wr_addr.size() != 0) begin
      failures++;
      $display("FAIL rst_mid_nowrite: writes got %0d want 0", wr_addr.size());
    end
    tick();
    test_basic_load(0, "after_rst");
  endtask

  task automatic test_start_while_busy();
    clear_log();
    pulse_start();
    send(8'h02);
    send(8'h00);
    send(8'h44);
    send(8'h33);
    start = 1'b1;
    send(8'h22);
    start = 1'b0;
    frm = '{8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h66};
    send_frame(0);
    tick();
    @(negedge clk);
    checks++;
    if (wr_addr.size() != 2 || wr_data[0] !== 32'h11223344 || wr_data[1] !== 32'hDEADBEEF ||
        wr_addr[1] !== 8'd1) begin
      failures++;
      $display("FAIL busy_start_writes: count=%0d d0=%h d1=%h a1=%h want 2 11223344 deadbeef 01",
               wr_addr.size(), wr_data[0], wr_data[1], wr_addr[1]);
    end
    checks++;
    if ({done, error, cpu_reset, words_loaded} !== {3'b100, 9'd2}) begin
      failures++;
      $display("FAIL busy_start_status: done/err/cpu_rst %b%b%b wl=%0d want 100 2",
               done, error, cpu_reset, words_loaded);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load(0, "basic");
    test_bad_checksum();
    test_zero_and_oversize();
    test_basic_load(3, "gaps");
    test_basic_load(3, "gaps2");
    test_reset_mid_load();
    test_start_while_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
